arcfour_stream: RTL and testbench

Parametrised RC4 keystream engine; next generation of the fixed 24-bit-key `arcfour` block. Drives the external 256x8 S-box RAM through init, KSA and PRGA. Supports a configurable key length and an RC4-drop[N] discard mode. Emits a bounded number of keystream bytes on a valid/ready stream to the downstream XOR/decrypt stage.

---
 rtl/arcfour_pkg.sv | 26 ++
 rtl/arcfour_stream_if.sv | 12 +
 rtl/arcfour_swap.sv | 83 ++++++++
 rtl/arcfour_stream.sv | 164 ++++++++++++++++
 tb/tb_arcfour_stream.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/arcfour_pkg.sv
// rtl/arcfour_pkg.sv - shared constants and state encoding for the RC4 keystream engine
package arcfour_pkg;

    localparam int SBOX_SIZE = 256;
    localparam int BYTE_W    = 8;

    typedef logic [3:0] arcfour_state_t;

    localparam arcfour_state_t ST_IDLE    = 4'd0;
    localparam arcfour_state_t ST_INIT    = 4'd1;
    localparam arcfour_state_t ST_KSA_RI  = 4'd2;
    localparam arcfour_state_t ST_KSA_RJ  = 4'd3;
    localparam arcfour_state_t ST_KSA_CJ  = 4'd4;
    localparam arcfour_state_t ST_KSA_WI  = 4'd5;
    localparam arcfour_state_t ST_KSA_WJ  = 4'd6;
    localparam arcfour_state_t ST_PRGA_RI = 4'd7;
    localparam arcfour_state_t ST_PRGA_RJ = 4'd8;
    localparam arcfour_state_t ST_PRGA_CJ = 4'd9;
    localparam arcfour_state_t ST_PRGA_WI = 4'd10;
    localparam arcfour_state_t ST_PRGA_WJ = 4'd11;
    localparam arcfour_state_t ST_PRGA_RK = 4'd12;
    localparam arcfour_state_t ST_PRGA_CK = 4'd13;
    localparam arcfour_state_t ST_OUT     = 4'd14;
    localparam arcfour_state_t ST_DONE    = 4'd15;

endpackage

// File: rtl/arcfour_stream_if.sv
// rtl/arcfour_stream_if.sv - keystream byte stream towards the XOR/decrypt stage
interface arcfour_stream_if;
    import arcfour_pkg::*;

    logic [BYTE_W-1:0] ks_data;
    logic              ks_valid;
    logic              ks_ready;

    modport master (output ks_data, output ks_valid, input ks_ready);
    modport slave  (input ks_data, input ks_valid, output ks_ready);

endinterface

// File: rtl/arcfour_swap.sv
// rtl/arcfour_swap.sv - read-read-write-write S[i]/S[j] swap sequencer shared by KSA and PRGA
module arcfour_swap
    import arcfour_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              go,
    input  logic [BYTE_W-1:0] i,
    input  logic [BYTE_W-1:0] j_in,
    input  logic [BYTE_W-1:0] add,
    input  logic [BYTE_W-1:0] ram_out,
    output logic [BYTE_W-1:0] address,
    output logic [BYTE_W-1:0] ram_in,
    output logic              write_enable,
    output logic [BYTE_W-1:0] si,
    output logic [BYTE_W-1:0] sj,
    output logic [BYTE_W-1:0] j_out,
    output logic              swap_done
);

    localparam logic [2:0] PH_RI = 3'd0;
    localparam logic [2:0] PH_RJ = 3'd1;
    localparam logic [2:0] PH_CJ = 3'd2;
    localparam logic [2:0] PH_WI = 3'd3;
    localparam logic [2:0] PH_WJ = 3'd4;

    logic [2:0]        phase;
    logic [BYTE_W-1:0] j_sum;

    // ram_out holds S[i] during RJ, so the new j is formed straight from it
    assign j_sum = j_in + ram_out + add;

    // Phase sequencing and capture of S[i], S[j] and the new j
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase <= PH_RI;
            si    <= '0;
            sj    <= '0;
            j_out <= '0;
        end else begin
            case (phase)
                PH_RI: if (go) phase <= PH_RJ;
                PH_RJ: begin
                    si    <= ram_out;
                    j_out <= j_sum;
                    phase <= PH_CJ;
                end
                PH_CJ: begin
                    sj    <= ram_out;
                    phase <= PH_WI;
                end
                PH_WI:   phase <= PH_WJ;
                default: phase <= PH_RI;
            endcase
        end
    end

    // RAM port drive for each phase
    always_comb begin
        address      = '0;
        ram_in       = '0;
        write_enable = 1'b0;
        swap_done    = 1'b0;
        case (phase)
            PH_RI: if (go) address = i;
            PH_RJ: address = j_sum;
            PH_CJ: address = j_out;
            PH_WI: begin
                address      = i;
                ram_in       = sj;
                write_enable = 1'b1;
            end
            PH_WJ: begin
                address      = j_out;
                ram_in       = si;
                write_enable = 1'b1;
                swap_done    = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/arcfour_stream.sv
// rtl/arcfour_stream.sv - parametrised RC4 keystream engine driving an external S-box RAM
module arcfour_stream
    import arcfour_pkg::*;
#(
    parameter int KEY_BYTES = 3,
    parameter int MSG_LEN   = 32,
    parameter int DROP_N    = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [8*KEY_BYTES-1:0] key,
    input  logic                   start_sig,
    input  logic [BYTE_W-1:0]      ram_out,
    output logic [BYTE_W-1:0]      address,
    output logic [BYTE_W-1:0]      ram_in,
    output logic                   write_enable,
    output logic                   busy,
    output logic                   arcfour_finished,
    arcfour_stream_if.master       ks
);

    localparam logic [4:0]        KIDX_LAST = 5'(KEY_BYTES - 1);
    localparam logic [11:0]       DROP_LIM  = 12'(DROP_N);
    localparam logic [15:0]       EMIT_LAST = 16'(MSG_LEN - 1);
    localparam logic [BYTE_W-1:0] I_LAST    = BYTE_W'(SBOX_SIZE - 1);

    arcfour_state_t    state;
    logic [BYTE_W-1:0] i, j, k;
    logic [4:0]        kidx;
    logic [11:0]       drop_cnt;
    logic [15:0]       emit_cnt;

    logic [BYTE_W-1:0] key_byte;
    logic              in_ksa, in_swap, sw_go, sw_we, sw_done;
    logic [BYTE_W-1:0] sw_i, sw_add, sw_address, sw_ram_in, sw_si, sw_sj, sw_j_out;

    assign in_ksa  = state inside {ST_KSA_RI, ST_KSA_RJ, ST_KSA_CJ, ST_KSA_WI, ST_KSA_WJ};
    assign in_swap = in_ksa || (state inside {ST_PRGA_RI, ST_PRGA_RJ, ST_PRGA_CJ, ST_PRGA_WI, ST_PRGA_WJ});
    assign sw_go   = (state == ST_KSA_RI) || (state == ST_PRGA_RI);
    // PRGA reads S[i+1] in the same cycle that i advances
    assign sw_i    = (state == ST_PRGA_RI) ? i + 8'd1 : i;
    assign sw_add  = in_ksa ? key_byte : '0;

    // Key byte selection by rolling index; byte 0 sits in the MSBs
    always_comb begin
        key_byte = '0;
        for (int n = 0; n < KEY_BYTES; n++) begin
            if (kidx == 5'(n)) key_byte = key[8*(KEY_BYTES-1-n) +: 8];
        end
    end

    arcfour_swap u_swap (
        .clk          (clk),
        .reset        (reset),
        .go           (sw_go),
        .i            (sw_i),
        .j_in         (j),
        .add          (sw_add),
        .ram_out      (ram_out),
        .address      (sw_address),
        .ram_in       (sw_ram_in),
        .write_enable (sw_we),
        .si           (sw_si),
        .sj           (sw_sj),
        .j_out        (sw_j_out),
        .swap_done    (sw_done)
    );

    // Main control FSM with run counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            i        <= '0;
            j        <= '0;
            k        <= '0;
            kidx     <= '0;
            drop_cnt <= '0;
            emit_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: if (start_sig) begin
                    state    <= ST_INIT;
                    i        <= '0;
                    j        <= '0;
                    kidx     <= '0;
                    drop_cnt <= '0;
                    emit_cnt <= '0;
                end
                ST_INIT: begin
                    i <= i + 8'd1;
                    if (i == I_LAST) state <= ST_KSA_RI;
                end
                ST_KSA_RI: state <= ST_KSA_RJ;
                ST_KSA_RJ: state <= ST_KSA_CJ;
                ST_KSA_CJ: state <= ST_KSA_WI;
                ST_KSA_WI: state <= ST_KSA_WJ;
                ST_KSA_WJ: if (sw_done) begin
                    j    <= sw_j_out;
                    i    <= i + 8'd1;
                    kidx <= (kidx == KIDX_LAST) ? '0 : kidx + 5'd1;
                    if (i == I_LAST) begin
                        state <= ST_PRGA_RI;
                        j     <= '0;
                    end else begin
                        state <= ST_KSA_RI;
                    end
                end
                ST_PRGA_RI: begin
                    i     <= i + 8'd1;
                    state <= ST_PRGA_RJ;
                end
                ST_PRGA_RJ: state <= ST_PRGA_CJ;
                ST_PRGA_CJ: state <= ST_PRGA_WI;
                ST_PRGA_WI: state <= ST_PRGA_WJ;
                ST_PRGA_WJ: if (sw_done) begin
                    j     <= sw_j_out;
                    state <= ST_PRGA_RK;
                end
                ST_PRGA_RK: state <= ST_PRGA_CK;
                ST_PRGA_CK: begin
                    k <= ram_out;
                    if (drop_cnt != DROP_LIM) begin
                        drop_cnt <= drop_cnt + 12'd1;
                        state    <= ST_PRGA_RI;
                    end else begin
                        state <= ST_OUT;
                    end
                end
                ST_OUT: if (ks.ks_ready) begin
                    emit_cnt <= emit_cnt + 16'd1;
                    state    <= (emit_cnt == EMIT_LAST) ? ST_DONE : ST_PRGA_RI;
                end
                ST_DONE: if (!start_sig) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // RAM port mux; the K address is held through OUT so backpressure is quiet
    always_comb begin
        address      = '0;
        ram_in       = '0;
        write_enable = 1'b0;
        case (state)
            ST_INIT: begin
                address      = i;
                ram_in       = i;
                write_enable = 1'b1;
            end
            ST_PRGA_RK, ST_PRGA_CK, ST_OUT: address = sw_si + sw_sj;
            default: if (in_swap) begin
                address      = sw_address;
                ram_in       = sw_ram_in;
                write_enable = sw_we;
            end
        endcase
    end

    assign ks.ks_valid       = (state == ST_OUT);
    assign ks.ks_data        = (state == ST_OUT) ? k : '0;
    assign busy              = (state != ST_IDLE) && (state != ST_DONE);
    assign arcfour_finished  = (state == ST_DONE);

endmodule

// File: tb/tb_arcfour_stream.sv
// tb/tb_arcfour_stream.sv - scoreboard bench for arcfour_stream with behavioural S-box RAMs
module tb_arcfour_stream;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [23:0] key0;
    logic [31:0] key1;
    logic [23:0] key2;
    logic        start_s [3];
    logic [7:0]  addr_w [3];
    logic [7:0]  din_w [3];
    logic [7:0]  rdat [3];
    logic        we_w [3];
    logic        busy_w [3];
    logic        fin_w [3];
    logic        v_w [3];
    logic [7:0]  d_w [3];
    logic        rdy [3];
    logic [7:0]  mem [3][256];
    logic [7:0]  exp_q [3][$];
    int          rdy_mode = 0;
    logic        rdy_val = 1'b1;

    arcfour_stream_if if0 ();
    arcfour_stream_if if1 ();
    arcfour_stream_if if2 ();

    assign if0.ks_ready = rdy[0];
    assign if1.ks_ready = rdy[1];
    assign if2.ks_ready = rdy[2];
    assign v_w[0] = if0.ks_valid;
    assign v_w[1] = if1.ks_valid;
    assign v_w[2] = if2.ks_valid;
    assign d_w[0] = if0.ks_data;
    assign d_w[1] = if1.ks_data;
    assign d_w[2] = if2.ks_data;

    arcfour_stream #(.KEY_BYTES(3), .MSG_LEN(5), .DROP_N(0)) dut0 (
        .clk(clk), .reset(reset), .key(key0), .start_sig(start_s[0]), .ram_out(rdat[0]),
        .address(addr_w[0]), .ram_in(din_w[0]), .write_enable(we_w[0]), .busy(busy_w[0]),
        .arcfour_finished(fin_w[0]), .ks(if0));

    arcfour_stream #(.KEY_BYTES(4), .MSG_LEN(5), .DROP_N(0)) dut1 (
        .clk(clk), .reset(reset), .key(key1), .start_sig(start_s[1]), .ram_out(rdat[1]),
        .address(addr_w[1]), .ram_in(din_w[1]), .write_enable(we_w[1]), .busy(busy_w[1]),
        .arcfour_finished(fin_w[1]), .ks(if1));

    arcfour_stream #(.KEY_BYTES(3), .MSG_LEN(3), .DROP_N(2)) dut2 (
        .clk(clk), .reset(reset), .key(key2), .start_sig(start_s[2]), .ram_out(rdat[2]),
        .address(addr_w[2]), .ram_in(din_w[2]), .write_enable(we_w[2]), .busy(busy_w[2]),
        .arcfour_finished(fin_w[2]), .ks(if2));

    // 256x8 RAMs with registered read
    always @(posedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (we_w[d]) mem[d][addr_w[d]] <= din_w[d];
            rdat[d] <= mem[d][addr_w[d]];
        end
    end

    // Downstream ready, changed just after each rising edge
    always @(posedge clk) begin
        #1;
        for (int d = 0; d < 3; d++) rdy[d] = (rdy_mode != 0) ? 1'($urandom_range(0, 1)) : rdy_val;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, got, expv);
        end
    endtask

    // Scoreboard monitor: every accepted byte must match the next expected one
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (v_w[d] === 1'b1 && rdy[d] === 1'b1) begin
                if (exp_q[d].size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL ks_extra_dut%0d got=%02h expected=none", d, d_w[d]);
                end else begin
                    check($sformatf("ks_byte_dut%0d", d), 32'(d_w[d]), 32'(exp_q[d].pop_front()));
                end
            end
        end
    end

    // Reference RC4: KSA, then PRGA with the first 'drop' bytes discarded
    task automatic model_push(input int d, input logic [255:0] k, input int klen, input int drop, input int n);
        int s [256];
        int i, j, t, kb;
        for (int x = 0; x < 256; x++) s[x] = x;
        j = 0;
        for (int x = 0; x < 256; x++) begin
            kb = int'(k[8*(klen-1-(x % klen)) +: 8]);
            j = (j + s[x] + kb) % 256;
            t = s[x]; s[x] = s[j]; s[j] = t;
        end
        i = 0;
        j = 0;
        for (int x = 0; x < drop + n; x++) begin
            i = (i + 1) % 256;
            j = (j + s[i]) % 256;
            t = s[i]; s[i] = s[j]; s[j] = t;
            if (x >= drop) exp_q[d].push_back(8'(s[(s[i] + s[j]) % 256]));
        end
    endtask

    task automatic push_bytes(input int d, input logic [39:0] v, input int n);
        for (int x = 0; x < n; x++) exp_q[d].push_back(v[8*(n-1-x) +: 8]);
    endtask

    task automatic start_run(input int d, output int c0);
        @(negedge clk);
        start_s[d] = 1'b1;
        c0 = cyc;
    endtask

    task automatic wait_first_valid(input int d, input int c0, input string name, input int exp_lat);
        int n = 0;
        while (v_w[d] !== 1'b1 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(cyc - c0), 32'(exp_lat));
    endtask

    task automatic wait_fin(input int d, input string name);
        int n = 0;
        while (fin_w[d] !== 1'b1 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_finished"}, 32'(fin_w[d]), 32'd1);
    endtask

    task automatic finish_run(input int d, input string name);
        wait_fin(d, name);
        start_s[d] = 1'b0;
        @(negedge clk);
        check({name, "_drained"}, 32'(exp_q[d].size()), 32'd0);
    endtask

    initial begin
        int c0;
        int bad;
        int n;
        logic [7:0] a0;

        for (int d = 0; d < 3; d++) start_s[d] = 1'b0;
        key0 = '0;
        key1 = '0;
        key2 = '0;
        repeat (3) @(negedge clk);

        check("rst_address", 32'(addr_w[0]), 32'd0);
        check("rst_ram_in", 32'(din_w[0]), 32'd0);
        check("rst_write_enable", 32'(we_w[0]), 32'd0);
        check("rst_ks_valid", 32'(v_w[0]), 32'd0);
        check("rst_ks_data", 32'(d_w[0]), 32'd0);
        check("rst_busy", 32'(busy_w[0]), 32'd0);
        check("rst_finished", 32'(fin_w[0]), 32'd0);
        reset = 1'b1;

        // Known vector "Key", INIT sweep, latency, start held through DONE
        key0 = 24'h4B6579;
        push_bytes(0, 40'hEB9F7781B7, 5);
        start_run(0, c0);
        bad = 0;
        for (int x = 0; x < 256; x++) begin
            @(negedge clk);
            if (we_w[0] !== 1'b1 || addr_w[0] !== 8'(x) || din_w[0] !== 8'(x)) bad++;
        end
        check("init_writes", 32'(bad), 32'd0);
        @(negedge clk);
        check("init_we_end", 32'(we_w[0]), 32'd0);
        bad = 0;
        for (int x = 0; x < 256; x++) if (mem[0][x] !== 8'(x)) bad++;
        check("init_ram", 32'(bad), 32'd0);
        wait_first_valid(0, c0, "latency_drop0", 1544);
        wait_fin(0, "key");
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (fin_w[0] !== 1'b1 || busy_w[0] !== 1'b0) bad++;
        end
        check("start_held_no_rerun", 32'(bad), 32'd0);
        start_s[0] = 1'b0;
        @(negedge clk);
        check("done_to_idle", 32'(fin_w[0]), 32'd0);
        check("key_drained", 32'(exp_q[0].size()), 32'd0);

        // Backpressure on the second byte
        push_bytes(0, 40'hEB9F7781B7, 5);
        start_run(0, c0);
        n = 0;
        while (v_w[0] !== 1'b1 && n < 5000) begin @(negedge clk); n++; end
        rdy_val = 1'b0;
        @(negedge clk);
        n = 0;
        while (v_w[0] !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        check("bp_second_valid", 32'(v_w[0]), 32'd1);
        a0 = addr_w[0];
        bad = 0;
        repeat (10) begin
            if (v_w[0] !== 1'b1 || d_w[0] !== 8'h9F || we_w[0] !== 1'b0 || addr_w[0] !== a0) bad++;
            @(negedge clk);
        end
        check("bp_hold", 32'(bad), 32'd0);
        rdy_val = 1'b1;
        finish_run(0, "bp");

        // Reset mid-KSA aborts at once; a fresh run starts cleanly
        push_bytes(0, 40'hEB9F7781B7, 5);
        start_run(0, c0);
        repeat (600) @(negedge clk);
        check("mid_run_busy", 32'(busy_w[0]), 32'd1);
        reset = 1'b0;
        #1;
        check("abort_address", 32'(addr_w[0]), 32'd0);
        check("abort_ram_in", 32'(din_w[0]), 32'd0);
        check("abort_write_enable", 32'(we_w[0]), 32'd0);
        check("abort_ks_valid", 32'(v_w[0]), 32'd0);
        check("abort_ks_data", 32'(d_w[0]), 32'd0);
        check("abort_busy", 32'(busy_w[0]), 32'd0);
        check("abort_finished", 32'(fin_w[0]), 32'd0);
        exp_q[0].delete();
        start_s[0] = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        push_bytes(0, 40'hEB9F7781B7, 5);
        start_run(0, c0);
        finish_run(0, "after_reset");

        // Random 3-byte keys with random ready
        rdy_mode = 1;
        repeat (4) begin
            key0 = 24'($urandom());
            model_push(0, {232'b0, key0}, 3, 0, 5);
            start_run(0, c0);
            finish_run(0, "rand_k3");
        end
        rdy_mode = 0;

        // 4-byte key: "Wiki" then random keys
        key1 = 32'h57696B69;
        push_bytes(1, 40'h6044DB6D41, 5);
        start_run(1, c0);
        wait_first_valid(1, c0, "latency_k4", 1544);
        finish_run(1, "wiki");
        rdy_mode = 1;
        repeat (2) begin
            key1 = $urandom();
            model_push(1, {224'b0, key1}, 4, 0, 5);
            start_run(1, c0);
            finish_run(1, "rand_k4");
        end
        rdy_mode = 0;

        // Drop-2 mode
        key2 = 24'h4B6579;
        push_bytes(2, 40'h7781B7, 3);
        start_run(2, c0);
        wait_first_valid(2, c0, "latency_drop2", 1558);
        finish_run(2, "drop2");
        rdy_mode = 1;
        key2 = 24'($urandom());
        model_push(2, {232'b0, key2}, 3, 2, 3);
        start_run(2, c0);
        finish_run(2, "rand_drop2");
        rdy_mode = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
